signal_detector: RTL and testbench
==================================

Name: signal_detector

Overview:
- Receive-side counterpart of signal_generator: samples the 2-bit symbol stream {x,y} produced by the generator in the divided clock domain.
- Detects a parameterised 4-symbol pattern and counts detections.
- Drives the count onto the 5 Basys LEDs.
- Instantiated beside signal_generator in top, on the same clk_div and reset, with the generator's x/y wired in.

Parameters:
- PATTERN, 8'b00_01_11_10: target sequence. PATTERN[7:6] is the first symbol received, PATTERN[1:0] the last. Each symbol is {x,y}.
- CNT_W, 5: width of the match counter. Must equal the LED count in top.

Ports:
- clk  input  1  divided system clock (clk_div); all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; a symbol is consumed only on cycles with en=1.
- x  input  1  symbol bit 1 from signal_generator.
- y  input  1  symbol bit 0 from signal_generator.
- clear  input  1  synchronous clear of the match counter.
- match  output  1  one-cycle pulse per detection.
- count  output  CNT_W  number of detections, modulo 2^CNT_W.
- state  output  2  FSM state code, for debug/ILA.
- led  output  [0:4]  count display: led[0]=count[4] … led[4]=count[0].

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, history=0, fill=0, match=0, count=0, led=0.
- Reset deassertion is used directly. There is no internal synchroniser, because clk_div is slow relative to the button.
- history: 8-bit shift register. On each en cycle, history <= {history[5:0], x, y}.
- fill: 3-bit count of valid symbols in history, saturating at 4.
- FSM states (state output code):
  - IDLE (2'b00): entered from reset. On the first en cycle, shift the symbol in, set fill=1, go to FILL.
  - FILL (2'b01): on each en, shift and increment fill. When fill reaches 4 on this edge, go to HUNT.
  - HUNT (2'b10): on each en, shift. Stay in HUNT.
  - 2'b11 is unused. If reached, next state is IDLE.
- Detection is evaluated on the post-shift value: on an en cycle where {history[5:0],x,y}==PATTERN and the post-update fill is 4, the block registers match=1 for exactly the next cycle.
  - Latency: the 4th pattern symbol is sampled on edge N; match is high from edge N through edge N+1.
  - The transition from FILL to HUNT and the first possible match occur on the same edge.
- en=0: history, fill and state hold. match is 0.
- Overlapping detections are counted; see the optional feature for the alternative. Example: PATTERN 01_01_01_01 matches on every symbol after the 4th in a run of 01s.
- count increments by 1 on the same edge that sets match=1. It wraps 2^CNT_W-1 → 0 with no flag.
- clear=1: count <= 0 on the next edge. Clear wins over a simultaneous increment. match is still asserted normally, and history/fill/state are unaffected.
- led is a direct combinational reorder of count, with no extra latency.
- Reset mid-sequence discards partial history. The next match requires 4 fresh en symbols.
- Inputs x and y come from logic in the same clock domain and are sampled without synchronisers.

Optional Feature:
- Macro: DETECT_NONOVERLAP_EN.
- Defined: on every match edge, history <= 0, fill <= 0 and state <= IDLE. The symbol that completed the match is not reused, so 4 new symbols are needed for the next match.
- Not defined: overlapping detection as specified in Behaviour. History is never cleared except by reset.

Test Plan:
- Reset/IDLE: hold reset=0 with en=1 and x/y toggling → match=0, count=0, led=5'b00000, state=00. After release with en=0 for 10 cycles → state stays 00.
- Basic detect (default PATTERN): feed symbols 00,01,11,10 on consecutive en cycles → state 00→01→01→01→10, and match=1 for one cycle, on the edge sampling 10. Then count=1, led[4]=1, led[0:3]=0.
- en gating: same four symbols with en=0 cycles interleaved (en pattern 1,0,0,1,1,0,1) → exactly one match, asserted on the edge of the last en; no match during en=0 cycles.
- Overlap: PATTERN=8'b01_01_01_01, six consecutive en cycles of {x,y}=01 → matches on symbols 4, 5 and 6, count=3. With DETECT_NONOVERLAP_EN defined → count=1.
- Wrap and clear: 32 detections → count returns to 0 and led=00000. Assert clear on the same edge as a match → count=0 and match=1.
- Reset mid-operation: feed 00,01,11, pulse reset low for half a cycle, then feed 10 → no match, state=01, fill=1.

Source files
------------

// File: rtl/signal_detector.sv
`default_nettype none
// ============================================================================
// Module      : signal_detector
// Description : Receive-side companion of signal_generator. Samples the
//               2-bit symbol stream {x,y} on en strobes, detects a 4-symbol
//               PATTERN, counts detections modulo 2^CNT_W and mirrors the
//               count onto the five board LEDs (led[0] = count MSB).
// Ports       : clk    - divided system clock, rising edge
//               reset  - asynchronous, active-low reset
//               en     - sample strobe; a symbol is consumed only when high
//               x, y   - symbol bits {x,y} from signal_generator
//               clear  - synchronous clear of the match counter
//               match  - registered one-cycle pulse per detection
//               count  - detection count, wraps silently
//               state  - FSM code (00 IDLE, 01 FILL, 10 HUNT) for debug
//               led    - bit-reversed view of count
// Options     : `define DETECT_NONOVERLAP_EN to restart the search after
//               every match (the completing symbol is not reused).
// Revision    : 1.0 - initial release
// ============================================================================
module signal_detector #(
    parameter logic [7:0] PATTERN = 8'b00_01_11_10,
    parameter int         CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             y,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic [0:4]       led
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        HUNT = 2'b10
    } state_t;

    localparam logic [2:0] c_fill_full = 3'd4;

    // Only the three most recent symbols need storing: the incoming symbol
    // completes the 8-bit comparison window, and the oldest symbol of that
    // window drops out on the same edge.
    logic [5:0]       history_q, history_d;
    logic [2:0]       fill_q, fill_d;
    state_t           state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [7:0]       w_window;
    logic [2:0]       w_fill_inc;
    logic             w_hit;

    always_comb begin
        w_window   = {history_q, x, y};
        w_fill_inc = (fill_q == c_fill_full) ? fill_q : fill_q + 3'd1;
        // Match uses the post-update fill so the FILL->HUNT edge can match.
        w_hit      = (w_window == PATTERN) && (w_fill_inc == c_fill_full);

        history_d = history_q;
        fill_d    = fill_q;
        state_d   = state_q;
        match_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    history_d = w_window[5:0];
                    fill_d    = 3'd1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (en) begin
                    history_d = w_window[5:0];
                    fill_d    = w_fill_inc;
                    match_d   = w_hit;
                    if (w_fill_inc == c_fill_full) begin
                        state_d = HUNT;
                    end
                end
            end
            HUNT: begin
                if (en) begin
                    history_d = w_window[5:0];
                    fill_d    = w_fill_inc;
                    match_d   = w_hit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DETECT_NONOVERLAP_EN
        // Restart the search so the completing symbol is not reused.
        if (match_d) begin
            history_d = '0;
            fill_d    = '0;
            state_d   = IDLE;
        end
`endif

        // Clear takes priority over a coincident detection.
        if (clear) begin
            count_d = '0;
        end else if (match_d) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history_q <= '0;
            fill_q    <= '0;
            state_q   <= IDLE;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign match = match_q;
    assign count = count_q;
    assign state = state_q;

    // led[0] shows the count MSB, led[4] the LSB.
    for (genvar i = 0; i < 5; i++) begin : g_led
        assign led[i] = count_q[CNT_W-1-i];
    end

endmodule
`default_nettype wire

// File: tb/tb_signal_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_signal_detector
// Description : Self-checking bench. Instance a uses the default pattern,
//               instance b uses 01_01_01_01. A symbol-list model predicts
//               match/count/state/led for both and is compared every cycle;
//               directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_detector;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       x     = 1'b0;
    logic       y     = 1'b0;
    logic       clear = 1'b0;

    logic       match_a, match_b;
    logic [4:0] count_a, count_b;
    logic [1:0] state_a, state_b;
    logic [0:4] led_a, led_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    signal_detector #(.PATTERN(8'b00_01_11_10), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y), .clear(clear),
        .match(match_a), .count(count_a), .state(state_a), .led(led_a)
    );

    signal_detector #(.PATTERN(8'b01_01_01_01), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .y(y), .clear(clear),
        .match(match_b), .count(count_b), .state(state_b), .led(led_b)
    );

    // ------------------------------------------------------------------
    // Model: remember every symbol received since the search (re)started;
    // a detection is the last four symbols equalling the pattern.
    // ------------------------------------------------------------------
    logic [7:0] pat [2]       = '{8'b00_01_11_10, 8'b01_01_01_01};
    int         nsym [2]      = '{0, 0};
    logic [1:0] syms [2][4096];
    logic       exp_match [2] = '{1'b0, 1'b0};
    logic [4:0] exp_count [2] = '{5'd0, 5'd0};
    logic       m_hit;
    logic [7:0] m_win;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                nsym[k]      = 0;
                exp_match[k] = 1'b0;
                exp_count[k] = 5'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_hit = 1'b0;
                if (en) begin
                    syms[k][nsym[k] % 4096] = {x, y};
                    nsym[k] = nsym[k] + 1;
                    if (nsym[k] >= 4) begin
                        m_win = {syms[k][(nsym[k]-4) % 4096], syms[k][(nsym[k]-3) % 4096],
                                 syms[k][(nsym[k]-2) % 4096], syms[k][(nsym[k]-1) % 4096]};
                        m_hit = (m_win == pat[k]);
                    end
                end
                exp_match[k] = m_hit;
                if (clear)      exp_count[k] = 5'd0;
                else if (m_hit) exp_count[k] = exp_count[k] + 5'd1;
`ifdef DETECT_NONOVERLAP_EN
                if (m_hit) nsym[k] = 0;
`endif
            end
        end
    end

    function automatic logic [1:0] exp_state(input int n);
        if (n == 0)     return 2'b00;
        else if (n < 4) return 2'b01;
        else            return 2'b10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    logic [0:4] el;
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) el[i] = exp_count[0][4-i];
        chk("a.match", {31'd0, match_a}, {31'd0, exp_match[0]});
        chk("a.count", {27'd0, count_a}, {27'd0, exp_count[0]});
        chk("a.state", {30'd0, state_a}, {30'd0, exp_state(nsym[0])});
        chk("a.led",   {27'd0, led_a},   {27'd0, el});
        for (int i = 0; i < 5; i++) el[i] = exp_count[1][4-i];
        chk("b.match", {31'd0, match_b}, {31'd0, exp_match[1]});
        chk("b.count", {27'd0, count_b}, {27'd0, exp_count[1]});
        chk("b.state", {30'd0, state_b}, {30'd0, exp_state(nsym[1])});
        chk("b.led",   {27'd0, led_b},   {27'd0, el});
    end

    // Apply inputs, then return 2 time units after the next rising edge.
    task automatic step(input logic e, input logic [1:0] s, input logic c);
        en    = e;
        {x, y} = s;
        clear = c;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        reset = 1'b1;
    endtask

    logic [1:0] pat_a_sym [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic       gate_en   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] gate_sym  [7] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [1:0] st_exp    [4] = '{2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        // Reset held with activity on the inputs.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'(i), 1'b0);
            chk("rst.match", {31'd0, match_a}, 32'd0);
            chk("rst.count", {27'd0, count_a}, 32'd0);
            chk("rst.led",   {27'd0, led_a},   32'd0);
            chk("rst.state", {30'd0, state_a}, 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 1'b0);
        chk("idle.state", {30'd0, state_a}, 32'd0);

        // Basic detection of 00,01,11,10.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat_a_sym[i], 1'b0);
            chk("basic.state", {30'd0, state_a}, {30'd0, st_exp[i]});
            chk("basic.match", {31'd0, match_a}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk("basic.count", {27'd0, count_a}, 32'd1);
        chk("basic.led",   {27'd0, led_a},   32'b00001);
        step(1'b0, 2'b00, 1'b0);
        chk("basic.pulse", {31'd0, match_a}, 32'd0);

        // en gating with idle cycles interleaved.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(gate_en[i], gate_sym[i], 1'b0);
            chk("gate.match", {31'd0, match_a}, (i == 6) ? 32'd1 : 32'd0);
        end
        chk("gate.count", {27'd0, count_a}, 32'd1);

        // Overlapping run of 01 on instance b.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'b01, 1'b0);
`ifdef DETECT_NONOVERLAP_EN
            chk("ovl.match", {31'd0, match_b}, (i == 3) ? 32'd1 : 32'd0);
`else
            chk("ovl.match", {31'd0, match_b}, (i >= 3) ? 32'd1 : 32'd0);
`endif
        end
`ifdef DETECT_NONOVERLAP_EN
        chk("ovl.count", {27'd0, count_b}, 32'd1);
`else
        chk("ovl.count", {27'd0, count_b}, 32'd3);
`endif

        // 32 detections wrap the counter back to zero.
        do_reset();
        for (int d = 0; d < 32; d++)
            for (int i = 0; i < 4; i++) step(1'b1, pat_a_sym[i], 1'b0);
        chk("wrap.match", {31'd0, match_a}, 32'd1);
        chk("wrap.count", {27'd0, count_a}, 32'd0);
        chk("wrap.led",   {27'd0, led_a},   32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, pat_a_sym[i], 1'b0);
        chk("wrap.count1", {27'd0, count_a}, 32'd1);

        // Clear coincident with a detection.
        for (int i = 0; i < 4; i++) step(1'b1, pat_a_sym[i], (i == 3) ? 1'b1 : 1'b0);
        chk("clr.match", {31'd0, match_a}, 32'd1);
        chk("clr.count", {27'd0, count_a}, 32'd0);
        step(1'b0, 2'b00, 1'b0);

        // Reset in the middle of a pattern discards the partial history.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, pat_a_sym[i], 1'b0);
        reset = 1'b0;
        #5;
        reset = 1'b1;
        step(1'b1, 2'b10, 1'b0);
        chk("mid.match", {31'd0, match_a}, 32'd0);
        chk("mid.state", {30'd0, state_a}, 32'd1);
        chk("mid.count", {27'd0, count_a}, 32'd0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
